// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the parametrised ALU (ula_param).
// Holds the operating-mode encoding, the operation codes used within each
// mode, and the control FSM state encoding.
package ula_pkg;

    // Operating mode selected by the 2-bit modo input
    typedef enum logic [1:0] {
        LOGIC = 2'b00,
        ARIT  = 2'b01,
        EXT   = 2'b10,
        RSV   = 2'b11
    } modo_t;

    // Control FSM: IDLE accepts work, MUL iterates the multiplier,
    // DONE presents the multiply result for one cycle
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } ula_state_t;

    // Logic mode operation codes
    localparam logic [2:0] OP_L_AND   = 3'b000;
    localparam logic [2:0] OP_L_NOTA  = 3'b001;
    localparam logic [2:0] OP_L_NOTB  = 3'b010;
    localparam logic [2:0] OP_L_OR    = 3'b011;
    localparam logic [2:0] OP_L_XOR   = 3'b100;
    localparam logic [2:0] OP_L_NAND  = 3'b101;
    localparam logic [2:0] OP_L_PASSA = 3'b110;
    localparam logic [2:0] OP_L_PASSB = 3'b111;

    // Arithmetic mode operation codes
    localparam logic [2:0] OP_A_ADD   = 3'b000;
    localparam logic [2:0] OP_A_SUB   = 3'b001;
    localparam logic [2:0] OP_A_ADDNB = 3'b010;
    localparam logic [2:0] OP_A_SUBNB = 3'b011;
    localparam logic [2:0] OP_A_INCA  = 3'b100;
    localparam logic [2:0] OP_A_DECA  = 3'b101;
    localparam logic [2:0] OP_A_INCB  = 3'b110;
    localparam logic [2:0] OP_A_DECB  = 3'b111;

    // Extended mode operation codes
    localparam logic [2:0] OP_E_SHL   = 3'b000;
    localparam logic [2:0] OP_E_SHR   = 3'b001;
    localparam logic [2:0] OP_E_SAR   = 3'b010;
    localparam logic [2:0] OP_E_ROL   = 3'b011;
    localparam logic [2:0] OP_E_MULLO = 3'b100;
    localparam logic [2:0] OP_E_MULHI = 3'b101;
    localparam logic [2:0] OP_E_RSV6  = 3'b110;
    localparam logic [2:0] OP_E_RSV7  = 3'b111;

endpackage

// File: rtl/ula_mult_seq.sv
// ula_mult_seq: sequential shift-add multiplier.
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset, aborts any multiply in flight
//   start   - load operands a/b and begin a WIDTH-step multiply
//   a, b    - unsigned operands, sampled only when start is high
//   product - 2*WIDTH-bit product, valid after the step flagged by done
//   done    - high during the final partial-product step, so product is
//             complete on the following cycle
module ula_mult_seq
    import ula_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;

    // done is combinational so the controller can leave its iteration state
    // on the same edge that performs the last accumulation
    assign done = busy && (cnt == LAST);

    // One partial product per cycle: add the shifted multiplicand when the
    // current multiplier LSB is set, then shift both for the next bit
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) begin
                product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_param.sv
// ula_param: parametrised ALU with valid/ready input handshake.
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   i_valid      - operation request
//   i_ready      - high only while idle; accept = i_valid && i_ready
//   A, B         - unsigned WIDTH-bit operands
//   modo         - 00 logic, 01 arithmetic, 10 extended, 11 reserved
//   operacao     - operation within the selected mode
//   o_valid      - one-cycle pulse when the result fields are updated
//   o_resultado  - WIDTH-bit result, held between pulses
//   o_overflow   - carry / borrow / overflow flag for the presented result
//   o_zero       - presented result equals zero
// Single-cycle ops register their result at the accept edge. Multiply runs
// WIDTH shift-add steps in ula_mult_seq and presents WIDTH+1 cycles later.
module ula_param
    import ula_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       modo,
    input  logic [2:0]       operacao,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_resultado,
    output logic             o_overflow,
    output logic             o_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    ula_state_t state;
    modo_t      mode;
    logic       accept;
    logic       is_mul;
    logic       mul_high;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH:0]     arith;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     nb_ext;
    logic [SHW-1:0]     rot_amt;
    logic [2*WIDTH-1:0] rot_full;

    logic [2*WIDTH-1:0] product;
    logic               mult_done;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;

    assign mode    = modo_t'(modo);
    assign i_ready = (state == IDLE);
    assign accept  = i_valid && i_ready;
    assign is_mul  = (mode == EXT) &&
                     ((operacao == OP_E_MULLO) || (operacao == OP_E_MULHI));

    assign a_ext  = {1'b0, A};
    assign b_ext  = {1'b0, B};
    assign nb_ext = {1'b0, ~B};

    ula_mult_seq #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (A),
        .b       (B),
        .product (product),
        .done    (mult_done)
    );

    // Select low or high half of the finished product; the low half flags
    // overflow whenever significant bits spilled into the high half
    always_comb begin
        mul_res = product[WIDTH-1:0];
        mul_ovf = |product[2*WIDTH-1:WIDTH];
        if (mul_high) begin
            mul_res = product[2*WIDTH-1:WIDTH];
            mul_ovf = 1'b0;
        end
    end

    // Single-cycle datapath. Arithmetic runs one bit wider so bit WIDTH
    // carries the carry-out or borrow. Rotate doubles A and keeps the upper
    // half of the shifted copy, which handles a zero amount without a special case.
    always_comb begin
        alu_res  = '0;
        alu_ovf  = 1'b0;
        arith    = '0;
        rot_amt  = SHW'(32'(B[SHW-1:0]) % 32'(WIDTH));
        rot_full = {A, A} << rot_amt;
        case (mode)
            LOGIC: begin
                case (operacao)
                    OP_L_AND:   alu_res = A & B;
                    OP_L_NOTA:  alu_res = ~A;
                    OP_L_NOTB:  alu_res = ~B;
                    OP_L_OR:    alu_res = A | B;
                    OP_L_XOR:   alu_res = A ^ B;
                    OP_L_NAND:  alu_res = ~(A & B);
                    OP_L_PASSA: alu_res = A;
                    OP_L_PASSB: alu_res = B;
                    default:    alu_res = '0;
                endcase
            end
            ARIT: begin
                case (operacao)
                    OP_A_ADD:   arith = a_ext + b_ext;
                    OP_A_SUB:   arith = a_ext - b_ext;
                    OP_A_ADDNB: arith = a_ext + nb_ext;
                    OP_A_SUBNB: arith = a_ext - nb_ext;
                    OP_A_INCA:  arith = a_ext + ONE;
                    OP_A_DECA:  arith = a_ext - ONE;
                    OP_A_INCB:  arith = b_ext + ONE;
                    OP_A_DECB:  arith = b_ext - ONE;
                    default:    arith = '0;
                endcase
                alu_res = arith[WIDTH-1:0];
                alu_ovf = arith[WIDTH];
            end
            EXT: begin
                case (operacao)
                    OP_E_SHL: begin
                        alu_res = {A[WIDTH-2:0], 1'b0};
                        alu_ovf = A[WIDTH-1];
                    end
                    OP_E_SHR: begin
                        alu_res = {1'b0, A[WIDTH-1:1]};
                        alu_ovf = A[0];
                    end
                    OP_E_SAR:   alu_res = {A[WIDTH-1], A[WIDTH-1:1]};
                    OP_E_ROL:   alu_res = rot_full[2*WIDTH-1:WIDTH];
                    OP_E_MULLO: alu_res = '0;
                    OP_E_MULHI: alu_res = '0;
                    OP_E_RSV6:  alu_res = '0;
                    OP_E_RSV7:  alu_res = '0;
                    default:    alu_res = '0;
                endcase
            end
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Control FSM and output registers. o_zero is always derived from the
    // value being written, never from the previously held o_resultado.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            mul_high    <= 1'b0;
            o_valid     <= 1'b0;
            o_resultado <= '0;
            o_overflow  <= 1'b0;
            o_zero      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state    <= MUL;
                            mul_high <= (operacao == OP_E_MULHI);
                        end else begin
                            o_resultado <= alu_res;
                            o_overflow  <= alu_ovf;
                            o_zero      <= (alu_res == '0);
                            o_valid     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (mult_done) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    o_resultado <= mul_res;
                    o_overflow  <= mul_ovf;
                    o_zero      <= (mul_res == '0);
                    o_valid     <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ula_param.md
Name: ula_param

Overview:
- Parametrised successor to the 6-bit ALU: WIDTH-bit operands, logic, arithmetic and extended (shift/multiply) modes.
- Valid/ready input handshake and registered outputs with a one-cycle o_valid pulse.
- Single-cycle ops complete one cycle after accept; multiply is a multi-cycle shift-add sequence.
- Sits between the operand register file / switch front-end and the result display/writeback path.

Parameters:
- WIDTH, 6, operand and result width in bits (≥2).
- SHW, $clog2(WIDTH), derived constant; not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- i_valid  input  1  operation request
- i_ready  output  1  block can accept; high only in IDLE
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- modo  input  2  00 logic, 01 arithmetic, 10 extended, 11 reserved
- operacao  input  3  operation select within modo
- o_valid  output  1  one-cycle pulse: result fields updated this cycle
- o_resultado  output  WIDTH  result
- o_overflow  output  1  carry/borrow/overflow flag
- o_zero  output  1  o_resultado == 0 for the result being presented

Behaviour:
- Accept occurs on a rising edge with i_valid && i_ready; A, B, modo and operacao are sampled only then.
- Reset (sync): state=IDLE; o_resultado=0, o_overflow=0, o_zero=0, o_valid=0; i_ready=1 from the next cycle. Reset mid-multiply aborts the operation with no o_valid.
- FSM states: IDLE, MUL, DONE.
  - IDLE + accept of a non-multiply op → result registered at the same edge; o_valid high the following cycle; stays IDLE; i_ready stays 1, so back-to-back ops are allowed every cycle.
  - IDLE + accept of a multiply op → MUL; i_ready=0.
  - MUL: one partial-product step per cycle for WIDTH cycles (counter 0..WIDTH-1), then → DONE.
  - DONE: registers the result with o_valid=1 for one cycle → IDLE.
  - Multiply latency: o_valid is high WIDTH+1 cycles after the accept edge.
- i_valid while i_ready=0 is ignored; there is no queueing.
- o_zero is computed from the new result in the same register update. It is never derived from the previous o_resultado.
- Outputs hold their last values while o_valid=0.
- Logic mode (00), o_overflow=0:
  - 000 A&B; 001 ~A; 010 ~B; 011 A|B
  - 100 A^B; 101 ~(A&B); 110 A; 111 B
- Arithmetic mode (01), computed at WIDTH+1 bits with zero-extended operands (1 = constant one):
  - 000 A+B; 001 A-B; 010 A+~B; 011 A-~B
  - 100 A+1; 101 A-1; 110 B+1; 111 B-1
  - o_resultado = low WIDTH bits; o_overflow = bit WIDTH (carry-out on add, borrow on subtract).
- Extended mode (10):
  - 000 A<<1, o_overflow = A[WIDTH-1]
  - 001 A>>1 logical, o_overflow = A[0]
  - 010 A>>>1 arithmetic, o_overflow = 0
  - 011 rotate-left A by B[SHW-1:0] mod WIDTH, o_overflow = 0
  - 100 MUL low: low WIDTH bits of A*B; o_overflow = (high half ≠ 0)
  - 101 MUL high: high WIDTH bits of A*B; o_overflow = 0
  - 110, 111 reserved: result 0, o_overflow=0, o_zero=1, single-cycle
- modo 11: same as reserved (single-cycle, result 0, o_zero=1).

Decomposition:
- Shared package ula_pkg holds:
  - modo_t enum: LOGIC, ARIT, EXT, RSV
  - op constants for every operacao code per mode
  - ula_state_t enum: IDLE, MUL, DONE
- Sub-module ula_mult_seq: shift-add multiplier with start, WIDTH-cycle iteration, 2*WIDTH-bit product and done; synchronous reset on the same reset port.
- All single-cycle datapath stays inline in ula_param.

Test Plan (WIDTH=6):
- Reset, then ARIT 000 with A=63, B=1 → next cycle o_valid=1, o_resultado=0, o_overflow=1, o_zero=1.
- ARIT 001 with A=5, B=7 → o_resultado=62, o_overflow=1, o_zero=0. Back-to-back LOGIC 101 with A=63, B=63 on the following cycle → o_resultado=0, o_zero=1, o_overflow=0.
- EXT 100 with A=9, B=9 → i_ready=0 for 7 cycles; o_valid exactly 7 cycles after accept; o_resultado=17, o_overflow=1. EXT 101 with the same operands → o_resultado=1.
- During a multiply, assert i_valid with ARIT 000 (A=1, B=1) → ignored; no extra o_valid; multiply result unchanged.
- Assert reset on the 3rd MUL cycle → all outputs 0, no o_valid, i_ready=1 next cycle; a new op then completes normally.
- EXT 011 with A=0b100001, B=2 → o_resultado=0b000110. modo=11 with any op → o_resultado=0, o_zero=1, single-cycle.
